// File: rtl/alu_seq.sv
// Sequential W-bit ALU with start/busy/done handshake, status flags,
// a shift-add multiplier and a one-bit-per-cycle rotator.
module alu_seq #(
   parameter int W  = 8,
   parameter int CW = $clog2(W)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [3:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           cin,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           flag_z,
   output logic           flag_n,
   output logic           flag_c,
   output logic           flag_v
);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   localparam logic [3:0] OP_AND = 4'h1, OP_OR  = 4'h2, OP_XOR = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4, OP_SUB = 4'h5, OP_SHL = 4'h6;
   localparam logic [3:0] OP_LSR = 4'h7, OP_ASR = 4'h8, OP_MUL = 4'h9;
   localparam logic [3:0] OP_ROL = 4'hA, OP_ROR = 4'hB;

   state_t           state_q, state_d;
   logic [3:0]       op_q;
   logic [CW-1:0]    cnt_q, last_q;
   logic [2*W-1:0]   acc_q, mcand_q;
   logic [W-1:0]     mplier_q, rot_q;
   logic             done_q, z_q, n_q, c_q, v_q;
   logic [2*W-1:0]   res_q;

   logic             accept, multi, last_step;
   logic [W:0]       add_sum, sub_dif;
   logic [2*W-1:0]   sc_res, step_res, mul_acc_nxt;
   logic             sc_c, sc_v, step_c;
   logic [W-1:0]     rol_nxt, ror_nxt;

   // Start is only honoured in IDLE; a zero-count rotate completes like a single-cycle op.
   assign accept    = (state_q == IDLE) && start;
   assign multi     = (op == OP_MUL) ||
                      (((op == OP_ROL) || (op == OP_ROR)) && (b[CW-1:0] != '0));
   assign last_step = (cnt_q == last_q);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && multi) state_d = EXEC;
         EXEC: if (last_step)       state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy   = (state_q == EXEC);
      done   = done_q;
      result = res_q;
      flag_z = z_q;
      flag_n = n_q;
      flag_c = c_q;
      flag_v = v_q;
   end

   // Single-cycle results, computed straight from the live operands
   always_comb begin
      add_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      sub_dif = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      sc_res  = '0;
      sc_c    = 1'b0;
      sc_v    = 1'b0;
      case (op)
         OP_AND: sc_res = {{W{1'b0}}, a & b};
         OP_OR:  sc_res = {{W{1'b0}}, a | b};
         OP_XOR: sc_res = {{W{1'b0}}, a ^ b};
         OP_ADD: begin
            sc_res = {{(W-1){1'b0}}, add_sum};
            sc_c   = add_sum[W];
            sc_v   = (a[W-1] == b[W-1]) && (add_sum[W-1] != a[W-1]);
         end
         OP_SUB: begin
            sc_res = {{W{1'b0}}, sub_dif[W-1:0]};
            sc_c   = sub_dif[W];
            sc_v   = (a[W-1] != b[W-1]) && (sub_dif[W-1] != a[W-1]);
         end
         OP_SHL: begin sc_res = {{W{1'b0}}, a[W-2:0], 1'b0};    sc_c = a[W-1]; end
         OP_LSR: begin sc_res = {{(W+1){1'b0}}, a[W-1:1]};      sc_c = a[0];   end
         OP_ASR: begin sc_res = {{W{1'b0}}, a[W-1], a[W-1:1]};  sc_c = a[0];   end
         OP_ROL, OP_ROR: sc_res = {{W{1'b0}}, a};
         default: sc_res = '0;
      endcase
   end

   // One iteration of the multi-cycle datapath
   always_comb begin
      mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
      rol_nxt     = {rot_q[W-2:0], rot_q[W-1]};
      ror_nxt     = {rot_q[0], rot_q[W-1:1]};
      step_res    = '0;
      step_c      = 1'b0;
      case (op_q)
         OP_MUL: begin step_res = mul_acc_nxt;          step_c = |mul_acc_nxt[2*W-1:W]; end
         OP_ROL: begin step_res = {{W{1'b0}}, rol_nxt}; step_c = rot_q[W-1];            end
         OP_ROR: begin step_res = {{W{1'b0}}, ror_nxt}; step_c = rot_q[0];              end
         default: begin step_res = '0;                  step_c = 1'b0;                  end
      endcase
   end

   // Datapath and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         cnt_q    <= '0;
         last_q   <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rot_q    <= '0;
         done_q   <= 1'b0;
         res_q    <= '0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            op_q     <= op;
            cnt_q    <= '0;
            last_q   <= (op == OP_MUL) ? CW'(W-1) : (b[CW-1:0] - 1'b1);
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= b;
            rot_q    <= a;
            if (!multi) begin
               res_q  <= sc_res;
               z_q    <= (sc_res == '0);
               n_q    <= sc_res[W-1];
               c_q    <= sc_c;
               v_q    <= sc_v;
               done_q <= 1'b1;
            end
         end else if (state_q == EXEC) begin
            acc_q    <= mul_acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rot_q    <= (op_q == OP_ROL) ? rol_nxt : ror_nxt;
            cnt_q    <= cnt_q + 1'b1;
            if (last_step) begin
               res_q  <= step_res;
               z_q    <= (step_res == '0);
               n_q    <= (op_q == OP_MUL) ? step_res[2*W-1] : step_res[W-1];
               c_q    <= step_c;
               v_q    <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq (W=8) against an arithmetic reference model,
// with directed cases for handshake timing, flags and reset behaviour.
module tb_alu_seq;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n, start, cin;
   logic [3:0]     op;
   logic [W-1:0]   a, b;
   logic           busy, done, flag_z, flag_n, flag_c, flag_v;
   logic [2*W-1:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2*W-1:0] exp_q[$];
   logic [3:0]     expf_q[$];

   alu_seq #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .result(result),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: result, {Z,N,C,V}, and clock edges from accept to done
   function automatic void model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input logic ci, output logic [15:0] r, output logic [3:0] f,
                                 output int lat);
      int xi, yi, sx, sy, s, sv, n;
      logic c, v;
      xi = int'(x); yi = int'(y);
      sx = int'($signed(x)); sy = int'($signed(y));
      c = 1'b0; v = 1'b0; lat = 0; r = '0;
      case (o)
         4'h1: r = {8'h00, x & y};
         4'h2: r = {8'h00, x | y};
         4'h3: r = {8'h00, x ^ y};
         4'h4: begin
            s = xi + yi + int'(ci); r = 16'(s);
            c = (s >= 256);
            sv = sx + sy + int'(ci); v = (sv > 127) || (sv < -128);
         end
         4'h5: begin
            s = xi - yi - int'(ci); r = 16'(s & 255);
            c = (s < 0);
            sv = sx - sy - int'(ci); v = (sv > 127) || (sv < -128);
         end
         4'h6: begin r = 16'((xi * 2) & 255); c = (xi >= 128); end
         4'h7: begin r = 16'(xi / 2);         c = (xi % 2 == 1); end
         4'h8: begin r = 16'((sx >>> 1) & 255); c = (xi % 2 == 1); end
         4'h9: begin r = 16'(xi * yi); c = (xi * yi >= 256); lat = 8; end
         4'hA: begin
            n = yi % 8; r = 16'(((xi << n) | (xi >> (8 - n))) & 255);
            c = (n != 0) && (r[0] == 1'b1); lat = n;
         end
         4'hB: begin
            n = yi % 8; r = 16'(((xi >> n) | (xi << (8 - n))) & 255);
            c = (n != 0) && (r[7] == 1'b1); lat = n;
         end
         default: r = '0;
      endcase
      f = {(r == 16'h0000), (o == 4'h9) ? r[15] : r[7], c, v};
   endfunction

   // Driver: issue one op from idle, wait for done, score result and flags
   task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input bit poke);
      logic [15:0] r;
      logic [3:0]  f;
      int lat, edges;
      model(o, x, y, ci, r, f, lat);
      exp_q.push_back(r);
      expf_q.push_back(f);
      start = 1'b1; op = o; a = x; b = y; cin = ci;
      tick();
      start = 1'b0;
      check("busy_after_accept", busy, lat > 0);
      edges = 0;
      while (!done && edges < 3 * W) begin
         if (poke && lat > 3 && edges == 1) begin
            start = 1'b1; op = 4'h3; a = ~x; b = ~y;
         end
         tick();
         start = 1'b0;
         edges++;
      end
      check("done_seen", done, 1);
      check("latency", edges, lat);
      check("result", result, exp_q.pop_front());
      check("flags_zncv", {flag_z, flag_n, flag_c, flag_v}, expf_q.pop_front());
      check("busy_at_done", busy, 0);
   endtask

   initial begin
      logic [15:0] r;
      logic [3:0]  f;
      logic [3:0]  o;
      int lat;
      bit saw_done;

      // Reset held with start asserted
      rst_n = 1'b0; start = 1'b1; op = 4'h4; a = 8'hFF; b = 8'h01; cin = 1'b1;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      start = 1'b0;
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (3) begin tick(); if (done) saw_done = 1'b1; end
      check("no_done_after_reset", saw_done, 0);

      // Directed cases
      run_op(4'h4, 8'hFF, 8'h01, 1'b1, 1'b0);
      run_op(4'h5, 8'h80, 8'h01, 1'b0, 1'b0);
      run_op(4'h0, 8'h5A, 8'hA5, 1'b1, 1'b0);
      run_op(4'h9, 8'hFF, 8'hFF, 1'b0, 1'b1);
      run_op(4'hA, 8'h81, 8'h03, 1'b0, 1'b0);
      run_op(4'hB, 8'h01, 8'h00, 1'b0, 1'b0);
      run_op(4'h8, 8'h81, 8'h00, 1'b0, 1'b0);
      run_op(4'hE, 8'hFF, 8'hFF, 1'b1, 1'b0);

      // Randomised ops
      for (int i = 0; i < 60; i++)
         run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom),
                1'($urandom_range(0, 1)));

      // Back-to-back single-cycle ops: done every cycle
      for (int i = 0; i < 5; i++) begin
         o = 4'($urandom_range(0, 8));
         start = 1'b1; op = o; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         model(o, a, b, cin, r, f, lat);
         exp_q.push_back(r);
         expf_q.push_back(f);
         tick();
         check("b2b_done", done, 1);
         check("b2b_result", result, exp_q.pop_front());
         check("b2b_flags", {flag_z, flag_n, flag_c, flag_v}, expf_q.pop_front());
      end
      start = 1'b0;
      tick();
      check("b2b_done_drops", done, 0);

      // MUL aborted by reset at the 4th edge after accept
      start = 1'b1; op = 4'h9; a = 8'hFF; b = 8'hFF; cin = 1'b0;
      tick();
      start = 1'b0;
      repeat (3) tick();
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      #3 rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (W + 2) begin tick(); if (done || busy) saw_done = 1'b1; end
      check("abort_no_done", saw_done, 0);

      // Final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
